uart_tx_serializer: RTL and testbench

UART transmit path: accepts a parallel byte with a valid strobe and shifts out a serial frame on TX_OUT. The frame is a start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, then one stop bit, at one bit per TX_clk cycle (TX_clk is the baud-rate clock). It sits between the ALU result path and the serial line, and is the transmit-side counterpart of the RX deserializer/sampler chain. It contains a control FSM, a bit counter, a shift register, and parity generation latched at frame acceptance.

---
 rtl/uart_tx_serializer.sv | 111 +++++++++++
 tb/tb_uart_tx_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// One bit per TX_clk cycle; TX_OUT and Busy come straight from flops.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (0) on the line
// DATA   | data bit shift_q[0] on the line, cnt_q counts bits sent
// PARITY | latched parity bit on the line
// STOP   | stop bit (1); a new word may be accepted here
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  TX_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge TX_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      IDLE, STOP: begin
        if (Data_Valid) begin
          state_d   = START;
          shift_d   = P_DATA;
          cnt_d     = '0;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = DATA;
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Decode from the next state so the output flops show the bit of the state being entered.
  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = 1'b0;
    case (state_d)
      IDLE:    begin tx_out_d = 1'b1;       busy_d = 1'b0; end
      START:   begin tx_out_d = 1'b0;       busy_d = 1'b1; end
      DATA:    begin tx_out_d = shift_d[0]; busy_d = 1'b1; end
      PARITY:  begin tx_out_d = par_bit_d;  busy_d = 1'b1; end
      STOP:    begin tx_out_d = 1'b1;       busy_d = 1'b0; end
      default: begin tx_out_d = 1'b1;       busy_d = 1'b0; end
    endcase
  end

  assign TX_OUT = tx_out_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: expected line/busy values are queued per cycle when a request is
// driven and compared every cycle; an empty queue means the line must be idle.
module tb_uart_tx_serializer;

  localparam int DW = 8;

  logic          TX_clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          Busy;

  int errors = 0;
  int checks = 0;
  string tag = "reset";

  // Each entry is {tx_out, busy} for one bit period.
  logic [1:0] sb[$];

  uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
    .TX_clk    (TX_clk),
    .rst_n     (rst_n),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 TX_clk = ~TX_clk;

  always @(posedge TX_clk) begin
    logic [1:0] exp;
    #2;
    if (sb.size() != 0) exp = sb.pop_front();
    else                exp = 2'b10;
    checks++;
    assert (TX_OUT === exp[1]) else begin
      errors++;
      $error("FAIL %s tx_out t=%0t observed=%b expected=%b", tag, $time, TX_OUT, exp[1]);
    end
    checks++;
    assert (Busy === exp[0]) else begin
      errors++;
      $error("FAIL %s busy t=%0t observed=%b expected=%b", tag, $time, Busy, exp[0]);
    end
  end

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    logic par;
    par = logic'($countones(d) % 2) ^ pt;
    sb.push_back(2'b01);
    for (int i = 0; i < DW; i++) sb.push_back({d[i], 1'b1});
    if (pe) sb.push_back({par, 1'b1});
    sb.push_back(2'b10);
  endtask

  // Called at a negedge; returns one negedge later with Data_Valid dropped.
  task automatic pulse(input logic [DW-1:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    push_frame(d, pe, pt);
    @(negedge TX_clk);
    Data_Valid = 1'b0;
  endtask

  // Returns at the negedge inside the stop-bit cycle of the last queued frame.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge TX_clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s drain_timeout observed=%0d pending expected=0", tag, sb.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (2) @(negedge TX_clk);
    rst_n      = 1'b1;
    Data_Valid = 1'b0;
    repeat (3) @(negedge TX_clk);

    tag = "t1_a5_nopar";
    pulse(8'hA5, 1'b0, 1'b0);
    drain(40);
    repeat (3) @(negedge TX_clk);

    tag = "t2_a5_even";
    pulse(8'hA5, 1'b1, 1'b0);
    drain(40);
    repeat (2) @(negedge TX_clk);
    tag = "t2_a5_odd";
    pulse(8'hA5, 1'b1, 1'b1);
    drain(40);
    repeat (2) @(negedge TX_clk);
    tag = "t2_00_odd";
    pulse(8'h00, 1'b1, 1'b1);
    drain(40);
    repeat (2) @(negedge TX_clk);

    tag = "t3_back_to_back";
    pulse(8'h55, 1'b0, 1'b0);
    drain(40);
    pulse(8'hFF, 1'b0, 1'b0);
    drain(40);
    repeat (3) @(negedge TX_clk);

    tag = "t4_ignore_midframe";
    pulse(8'h0F, 1'b1, 1'b0);
    repeat (4) @(negedge TX_clk);
    Data_Valid = 1'b1;
    P_DATA     = 8'h12;
    PAR_TYP    = 1'b1;
    PAR_EN     = 1'b0;
    @(negedge TX_clk);
    Data_Valid = 1'b0;
    P_DATA     = 8'h34;
    drain(40);
    repeat (3) @(negedge TX_clk);

    tag = "t5_reset_abort";
    pulse(8'hC3, 1'b0, 1'b0);
    repeat (3) @(negedge TX_clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge TX_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge TX_clk);
    tag = "t5_after_reset";
    pulse(8'h3C, 1'b0, 1'b0);
    drain(40);
    repeat (3) @(negedge TX_clk);

    tag = "t6_held_valid";
    P_DATA     = 8'h81;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    push_frame(8'h81, 1'b1, 1'b0);
    drain(40);
    P_DATA  = 8'h7E;
    PAR_TYP = 1'b1;
    push_frame(8'h7E, 1'b1, 1'b1);
    drain(40);
    P_DATA  = 8'h01;
    PAR_TYP = 1'b1;
    push_frame(8'h01, 1'b1, 1'b1);
    drain(40);
    P_DATA  = 8'hF0;
    PAR_TYP = 1'b0;
    push_frame(8'hF0, 1'b1, 1'b0);
    drain(40);
    Data_Valid = 1'b0;
    repeat (4) @(negedge TX_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
